stage3_trap_sequencer: RTL

- Multi-cycle controller for the 3-stage pipeline's trap, interrupt and xRET redirect path.
- Sits beside the hazard unit. Watches mem-stage exception and return status, drains outstanding memory traffic, and handshakes with the privilege unit.
- Drives flush/stall/PC-insertion requests that the hazard unit ORs into its pipeline controls.
- Replaces the single-cycle combinational trap path so slow memories and a registered privilege unit are tolerated.

---
 rtl/trap_seq_pkg.sv | 39 +++
 rtl/trap_seq_prio_enc.sv | 41 ++++
 rtl/stage3_trap_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/trap_seq_pkg.sv
// Shared types and constants for the stage-3 trap/interrupt/xRET redirect sequencer.
package trap_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    REQ,
    REDIRECT,
    SLEEP
  } trap_seq_state_t;

  typedef enum logic {
    TRAP,
    RET
  } trap_seq_kind_t;

  // exc_flags bit positions
  localparam int unsigned ExcMalInsn    = 0;
  localparam int unsigned ExcFaultInsn  = 1;
  localparam int unsigned ExcIllegal    = 2;
  localparam int unsigned ExcMalL       = 3;
  localparam int unsigned ExcFaultL     = 4;
  localparam int unsigned ExcMalS       = 5;
  localparam int unsigned ExcFaultS     = 6;
  localparam int unsigned ExcBreakpoint = 7;
  localparam int unsigned ExcEnv        = 8;

  // Machine-mode exception cause codes
  localparam logic [4:0] CauseMalInsn    = 5'd0;
  localparam logic [4:0] CauseFaultInsn  = 5'd1;
  localparam logic [4:0] CauseIllegal    = 5'd2;
  localparam logic [4:0] CauseBreakpoint = 5'd3;
  localparam logic [4:0] CauseMalL       = 5'd4;
  localparam logic [4:0] CauseFaultL     = 5'd5;
  localparam logic [4:0] CauseMalS       = 5'd6;
  localparam logic [4:0] CauseFaultS     = 5'd7;
  localparam logic [4:0] CauseEnv        = 5'd11;

endpackage

// File: rtl/trap_seq_prio_enc.sv
// Priority encoder selecting the architecturally first exception among the mem-stage flags.
module trap_seq_prio_enc
  import trap_seq_pkg::*;
(
  input  logic [8:0] exc_flags,
  output logic       valid,
  output logic [4:0] code,
  output logic       uses_badaddr
);

  // Highest-priority flag wins; env calls carry no faulting address.
  always_comb begin
    valid        = 1'b1;
    code         = 5'd0;
    uses_badaddr = 1'b1;
    if (exc_flags[ExcBreakpoint]) begin
      code = CauseBreakpoint;
    end else if (exc_flags[ExcFaultInsn]) begin
      code = CauseFaultInsn;
    end else if (exc_flags[ExcIllegal]) begin
      code = CauseIllegal;
    end else if (exc_flags[ExcMalInsn]) begin
      code = CauseMalInsn;
    end else if (exc_flags[ExcEnv]) begin
      code         = CauseEnv;
      uses_badaddr = 1'b0;
    end else if (exc_flags[ExcMalS]) begin
      code = CauseMalS;
    end else if (exc_flags[ExcMalL]) begin
      code = CauseMalL;
    end else if (exc_flags[ExcFaultS]) begin
      code = CauseFaultS;
    end else if (exc_flags[ExcFaultL]) begin
      code = CauseFaultL;
    end else begin
      valid        = 1'b0;
      uses_badaddr = 1'b0;
    end
  end

endmodule

// File: rtl/stage3_trap_sequencer.sv
// Multi-cycle trap/interrupt/xRET redirect controller for the 3-stage pipeline.
// Drains outstanding memory traffic, handshakes with the privilege unit and
// inserts the returned PC into fetch. All outputs are registered.
// Optional macro TRAP_SEQ_WFI_EN adds a SLEEP state entered on WFI.
module stage3_trap_sequencer
  import trap_seq_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned WORD_W      = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              valid_m,
  input  logic [WORD_W-1:0] pc_m,
  input  logic [WORD_W-1:0] badaddr,
  input  logic [8:0]        exc_flags,
  input  logic              ret,
  input  logic              intr_req,
  input  logic [4:0]        intr_code,
  input  logic              wfi,
  input  logic              i_mem_busy,
  input  logic              d_mem_busy,
  output logic              trap_req,
  output logic              ret_req,
  input  logic              trap_ack,
  input  logic [WORD_W-1:0] priv_pc_in,
  output logic [WORD_W-1:0] epc,
  output logic [WORD_W-1:0] cause,
  output logic [WORD_W-1:0] tval,
  output logic              flush_all,
  output logic              stall_all,
  output logic              insert_priv_pc,
  output logic [WORD_W-1:0] priv_pc_o,
  input  logic              fetch_accept,
  output logic              busy,
  output logic              timeout_err
);

  // Counter holds completed REQ cycles, so it never needs to reach ACK_TIMEOUT itself.
  localparam int unsigned CntW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned TLast = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;

  trap_seq_state_t   state_q, state_d;
  trap_seq_kind_t    kind_q, kind_d;
  logic [WORD_W-1:0] epc_q, epc_d, cause_q, cause_d, tval_q, tval_d, ppc_q, ppc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              tmo_q, tmo_d;
  logic              flush_q, flush_d, stall_q, stall_d, treq_q, treq_d;
  logic              rreq_q, rreq_d, ins_q, ins_d, busy_q, busy_d;

  logic              enc_valid, enc_uses_badaddr;
  logic [4:0]        enc_code;

  trap_seq_prio_enc u_prio_enc (
    .exc_flags    (exc_flags),
    .valid        (enc_valid),
    .code         (enc_code),
    .uses_badaddr (enc_uses_badaddr)
  );

`ifndef TRAP_SEQ_WFI_EN
  logic unused_wfi;
  assign unused_wfi = wfi;
`endif

  // Next-state, latched trap context and registered-output decode.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    tval_d  = tval_q;
    ppc_d   = ppc_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_m) begin
          if (enc_valid) begin
            state_d       = DRAIN;
            kind_d        = TRAP;
            epc_d         = pc_m;
            cause_d       = '0;
            cause_d[4:0]  = enc_code;
            tval_d        = enc_uses_badaddr ? badaddr : '0;
          end else if (intr_req) begin
            state_d             = DRAIN;
            kind_d              = TRAP;
            epc_d               = pc_m;
            cause_d             = '0;
            cause_d[WORD_W-1]   = 1'b1;
            cause_d[4:0]        = intr_code;
            tval_d              = '0;
          end else if (ret) begin
            // xRET keeps the previous cause/tval visible to software.
            state_d = DRAIN;
            kind_d  = RET;
            epc_d   = pc_m;
`ifdef TRAP_SEQ_WFI_EN
          end else if (wfi) begin
            // Resume point after the WFI is the next instruction.
            state_d = SLEEP;
            epc_d   = pc_m + WORD_W'(4);
`endif
          end
        end
      end
      DRAIN: begin
        if (!(i_mem_busy || d_mem_busy)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (trap_ack) begin
          state_d = REDIRECT;
          ppc_d   = priv_pc_in;
          cnt_d   = '0;
        end else if ((ACK_TIMEOUT != 0) && (cnt_q == CntW'(TLast))) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      REDIRECT: begin
        if (fetch_accept) begin
          state_d = IDLE;
        end
      end
`ifdef TRAP_SEQ_WFI_EN
      SLEEP: begin
        if (intr_req) begin
          state_d           = DRAIN;
          kind_d            = TRAP;
          cause_d           = '0;
          cause_d[WORD_W-1] = 1'b1;
          cause_d[4:0]      = intr_code;
          tval_d            = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    flush_d = (state_d == DRAIN);
    stall_d = (state_d == DRAIN) || (state_d == REQ) || (state_d == SLEEP);
    treq_d  = (state_d == REQ) && (kind_d == TRAP);
    rreq_d  = (state_d == REQ) && (kind_d == RET);
    ins_d   = (state_d == REDIRECT);
    busy_d  = (state_d != IDLE);
  end

  // State, context and output registers; reset aborts any sequence in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      kind_q  <= TRAP;
      epc_q   <= '0;
      cause_q <= '0;
      tval_q  <= '0;
      ppc_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      flush_q <= 1'b0;
      stall_q <= 1'b0;
      treq_q  <= 1'b0;
      rreq_q  <= 1'b0;
      ins_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
      ppc_q   <= ppc_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      flush_q <= flush_d;
      stall_q <= stall_d;
      treq_q  <= treq_d;
      rreq_q  <= rreq_d;
      ins_q   <= ins_d;
      busy_q  <= busy_d;
    end
  end

  assign trap_req       = treq_q;
  assign ret_req        = rreq_q;
  assign epc            = epc_q;
  assign cause          = cause_q;
  assign tval           = tval_q;
  assign flush_all      = flush_q;
  assign stall_all      = stall_q;
  assign insert_priv_pc = ins_q;
  assign priv_pc_o      = ppc_q;
  assign busy           = busy_q;
  assign timeout_err    = tmo_q;

endmodule
